// File: rtl/icache_ctrl_pkg.sv
// Shared system definitions for the instruction cache: address width,
// memory bus command encoding and the miss-handling FSM states.
package icache_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned LINE_W = 64;
  localparam int unsigned OFF_W  = 3;

  typedef enum logic [1:0] {
    BUS_NONE = 2'h0,
    BUS_LOAD = 2'h1
  } bus_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'h0,
    REQ  = 2'h1,
    WAIT = 2'h2
  } icache_state_e;

  // Clears the byte-offset bits so the address names a whole 64-bit line.
  function automatic logic [XLEN-1:0] line_addr(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'((1 << OFF_W) - 1);
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled.
// slave is the cache; master is the fetch unit plus memory model.
interface icache_ctrl_if #(
  parameter int unsigned TAG_W = 4
);
  import icache_ctrl_pkg::*;

  logic [XLEN-1:0]   proc2Icache_addr;
  logic [LINE_W-1:0] Icache2proc_data;
  logic              Icache2proc_data_valid;
  bus_cmd_e          proc2mem_command;
  logic [XLEN-1:0]   proc2mem_addr;
  logic [TAG_W-1:0]  mem2proc_response;
  logic [LINE_W-1:0] mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_tag;

  modport slave (
    input  proc2Icache_addr,
    input  mem2proc_response,
    input  mem2proc_data,
    input  mem2proc_tag,
    output Icache2proc_data,
    output Icache2proc_data_valid,
    output proc2mem_command,
    output proc2mem_addr
  );

  modport master (
    output proc2Icache_addr,
    output mem2proc_response,
    output mem2proc_data,
    output mem2proc_tag,
    input  Icache2proc_data,
    input  Icache2proc_data_valid,
    input  proc2mem_command,
    input  proc2mem_addr
  );

endinterface

// File: rtl/icache_mem.sv
// Direct-mapped tag/valid/data storage: one registered write port and one
// asynchronous read port. Only the valid bits are reset.
module icache_mem
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned LTAG_W    = 24,
  localparam int unsigned IDX_W    = $clog2(NUM_LINES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [LTAG_W-1:0] wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [LTAG_W-1:0] rd_tag,
  output logic [LINE_W-1:0] rd_data
);

  logic [NUM_LINES-1:0] valid;
  logic [LTAG_W-1:0]    tags  [NUM_LINES];
  logic [LINE_W-1:0]    lines [NUM_LINES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = lines[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: zero-latency lookup and a
// single outstanding tagged line fill from memory.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned TAG_W     = 4
) (
  input  logic         clock,
  input  logic         reset,
  icache_ctrl_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned LTAG_W = XLEN - OFF_W - IDX_W;

  icache_state_e    state, state_n;
  logic [XLEN-1:0]  miss_addr, miss_addr_n;
  logic [TAG_W-1:0] pend_tag, pend_tag_n;
  logic             fill_en;

  logic [XLEN-1:0]   cur_line;
  logic [IDX_W-1:0]  cur_idx;
  logic [LTAG_W-1:0] cur_tag;
  logic              rd_valid;
  logic [LTAG_W-1:0] rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              hit;

  assign cur_line = line_addr(bus.proc2Icache_addr);
  assign cur_idx  = cur_line[OFF_W +: IDX_W];
  assign cur_tag  = cur_line[XLEN-1 -: LTAG_W];

  icache_mem #(
    .NUM_LINES (NUM_LINES),
    .LTAG_W    (LTAG_W)
  ) u_mem (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (fill_en),
    .wr_idx   (miss_addr[OFF_W +: IDX_W]),
    .wr_tag   (miss_addr[XLEN-1 -: LTAG_W]),
    .wr_data  (bus.mem2proc_data),
    .rd_idx   (cur_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign hit = rd_valid && (rd_tag == cur_tag);

  assign bus.Icache2proc_data_valid = hit;
  assign bus.Icache2proc_data       = rd_data;
  assign bus.proc2mem_command       = (state == REQ) ? BUS_LOAD : BUS_NONE;
  assign bus.proc2mem_addr          = miss_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      miss_addr <= '0;
      pend_tag  <= '0;
    end else begin
      state     <= state_n;
      miss_addr <= miss_addr_n;
      pend_tag  <= pend_tag_n;
    end
  end

  // Acceptance in REQ wins over a same-cycle redirect: the old request was
  // already on the bus and memory has committed to it.
  always_comb begin
    state_n     = state;
    miss_addr_n = miss_addr;
    pend_tag_n  = pend_tag;
    fill_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!hit) begin
          miss_addr_n = cur_line;
          state_n     = REQ;
        end
      end
      REQ: begin
        if (bus.mem2proc_response != '0) begin
          pend_tag_n = bus.mem2proc_response;
          state_n    = WAIT;
        end else if (cur_line != miss_addr) begin
          if (hit) begin
            state_n = IDLE;
          end else begin
            miss_addr_n = cur_line;
          end
        end
      end
      WAIT: begin
        if ((pend_tag != '0) && (bus.mem2proc_tag == pend_tag)) begin
          fill_en    = 1'b1;
          pend_tag_n = '0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: reset, fill, rejection retry, redirects,
// index conflicts, stray tags and reset during an outstanding miss.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;

  icache_ctrl_if #(.TAG_W(4)) bus ();

  icache_ctrl #(
    .NUM_LINES (32),
    .TAG_W     (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_miss_idle(input string tag);
    #1;
    chk({tag, "_valid"}, 64'(bus.Icache2proc_data_valid), 64'd0);
    chk({tag, "_cmd"}, 64'(bus.proc2mem_command), 64'(BUS_NONE));
  endtask

  task automatic chk_load(input string tag, input logic [31:0] addr);
    #1;
    chk({tag, "_cmd"}, 64'(bus.proc2mem_command), 64'(BUS_LOAD));
    chk({tag, "_addr"}, 64'(bus.proc2mem_addr), 64'(addr));
  endtask

  task automatic chk_hit(input string tag, input logic [63:0] data);
    #1;
    chk({tag, "_valid"}, 64'(bus.Icache2proc_data_valid), 64'd1);
    chk({tag, "_data"}, bus.Icache2proc_data, data);
  endtask

  localparam logic [63:0] D0 = 64'hDEADBEEF_00000013;
  localparam logic [63:0] D1 = 64'h11112222_33334444;
  localparam logic [63:0] D2 = 64'hA5A5A5A5_5A5A5A5A;
  localparam logic [63:0] D3 = 64'h0000_0040_CAFE_0003;
  localparam logic [63:0] D4 = 64'h0000_0080_CAFE_0004;
  localparam logic [63:0] D5 = 64'h0000_0100_CAFE_0005;
  localparam logic [63:0] DJ = 64'hBAD0BAD0_BAD0BAD0;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.proc2Icache_addr  = 32'h0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_data     = 64'd0;
    bus.mem2proc_tag      = 4'd0;

    // Reset state, visible before any clock edge.
    #1;
    chk("rst_valid", 64'(bus.Icache2proc_data_valid), 64'd0);
    chk("rst_cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    chk("rst_addr", 64'(bus.proc2mem_addr), 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // Cold miss at 0x0, accepted with tag 3, data two cycles later.
    chk_miss_idle("cold_idle");
    tick();
    chk_load("cold_req", 32'h0);
    bus.mem2proc_response = 4'd3;
    tick();
    bus.mem2proc_response = 4'd0;
    chk_miss_idle("cold_wait");
    tick();
    bus.mem2proc_tag  = 4'd3;
    bus.mem2proc_data = D0;
    chk_miss_idle("cold_nobypass");
    tick();
    bus.mem2proc_tag = 4'd0;
    chk_hit("cold_hit", D0);

    // Rejected three times, then accepted with tag 5.
    bus.proc2Icache_addr = 32'h0000_000C;
    chk_miss_idle("rej_idle");
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_load($sformatf("rej_retry%0d", i), 32'h0000_0008);
      tick();
    end
    bus.mem2proc_response = 4'd5;
    chk_load("rej_accept", 32'h0000_0008);
    tick();
    bus.mem2proc_response = 4'd0;
    chk_miss_idle("rej_wait");
    bus.mem2proc_tag  = 4'd5;
    bus.mem2proc_data = D1;
    tick();
    bus.mem2proc_tag = 4'd0;
    chk_hit("rej_hit", D1);

    // Redirect in REQ from 0x100 to 0x208 before acceptance.
    bus.proc2Icache_addr = 32'h0000_0100;
    tick();
    chk_load("redir_req_old", 32'h0000_0100);
    bus.proc2Icache_addr = 32'h0000_0208;
    tick();
    chk_load("redir_req_new", 32'h0000_0208);
    bus.mem2proc_response = 4'd6;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = 4'd6;
    bus.mem2proc_data     = D2;
    tick();
    bus.mem2proc_tag = 4'd0;
    chk_hit("redir_req_hit", D2);
    bus.proc2Icache_addr = 32'h0000_0000;
    chk_hit("redir_req_no100", D0);

    // Redirect in WAIT: 0x40 fill completes, then 0x80 is requested.
    bus.proc2Icache_addr = 32'h0000_0040;
    tick();
    chk_load("redir_wait_req", 32'h0000_0040);
    bus.mem2proc_response = 4'd2;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.proc2Icache_addr  = 32'h0000_0080;
    chk_miss_idle("redir_wait_wait");
    bus.mem2proc_tag  = 4'd2;
    bus.mem2proc_data = D3;
    tick();
    bus.mem2proc_tag = 4'd0;
    chk_miss_idle("redir_wait_idle80");
    tick();
    chk_load("redir_wait_req80", 32'h0000_0080);
    bus.mem2proc_response = 4'd1;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = 4'd1;
    bus.mem2proc_data     = D4;
    tick();
    bus.mem2proc_tag = 4'd0;
    chk_hit("redir_wait_hit80", D4);
    bus.proc2Icache_addr = 32'h0000_0044;
    chk_hit("redir_wait_hit40", D3);

    // Conflict at index 0 with a stray tag 7 during the wait for tag 2.
    bus.proc2Icache_addr = 32'h0000_0100;
    tick();
    chk_load("confl_req", 32'h0000_0100);
    bus.mem2proc_response = 4'd2;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = 4'd7;
    bus.mem2proc_data     = DJ;
    tick();
    chk_miss_idle("confl_stray");
    bus.mem2proc_tag  = 4'd2;
    bus.mem2proc_data = D5;
    tick();
    bus.mem2proc_tag = 4'd0;
    chk_hit("confl_hit100", D5);
    bus.proc2Icache_addr = 32'h0000_0000;
    chk_miss_idle("confl_miss0");

    // Reset during WAIT with tag 4 pending; late data must be dropped.
    tick();
    chk_load("rstw_req", 32'h0000_0000);
    bus.mem2proc_response = 4'd4;
    tick();
    bus.mem2proc_response = 4'd0;
    reset                 = 1'b1;
    bus.proc2Icache_addr  = 32'h0000_0100;
    chk_miss_idle("rstw_async");
    chk("rstw_addr", 64'(bus.proc2mem_addr), 64'd0);
    tick();
    reset = 1'b0;
    bus.proc2Icache_addr = 32'h0000_0000;
    tick();
    bus.mem2proc_tag  = 4'd4;
    bus.mem2proc_data = DJ;
    tick();
    bus.mem2proc_tag = 4'd0;
    #1;
    chk("rstw_late_valid", 64'(bus.Icache2proc_data_valid), 64'd0);
    chk("rstw_late_cmd", 64'(bus.proc2mem_command), 64'(BUS_LOAD));
    bus.proc2Icache_addr = 32'h0000_0100;
    #1;
    chk("rstw_100_valid", 64'(bus.Icache2proc_data_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 32, number of direct-mapped 64-bit lines (power of two, >=2).
REQ-002 Parameter TAG_W, default 4, width of memory transaction tags.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 proc2Icache_addr  input  XLEN  fetch address from ifetch; bits [2:0] ignored.
REQ-006 Icache2proc_data  output  64  line data for proc2Icache_addr; don't-care when invalid.
REQ-007 Icache2proc_data_valid  output  1  high when Icache2proc_data is a hit for the current address.
REQ-008 proc2mem_command  output  2  BUS_NONE or BUS_LOAD.
REQ-009 proc2mem_addr  output  XLEN  line-aligned miss address, bits [2:0] = 0.
REQ-010 mem2proc_response  input  TAG_W  transaction tag for an accepted request; 0 = rejected.
REQ-011 mem2proc_data  input  64  fill data, qualified by mem2proc_tag.
REQ-012 mem2proc_tag  input  TAG_W  tag of returning data; 0 = no data this cycle.

Function
REQ-013 Index = addr[3+log2(NUM_LINES)-1:3]; tag = addr[XLEN-1:3+log2(NUM_LINES)].
REQ-014 Hit = line valid AND stored tag equals address tag; Icache2proc_data_valid and Icache2proc_data driven combinationally, zero-cycle lookup latency.
REQ-015 FSM states: IDLE, REQ, WAIT; one outstanding miss at most.
REQ-016 IDLE: on miss, latch line address, go REQ next cycle; on hit, stay IDLE with BUS_NONE.
REQ-017 REQ: drive BUS_LOAD with latched address; if mem2proc_response != 0, latch it as pending tag and go WAIT; if 0, hold BUS_LOAD and retry next cycle.
REQ-018 REQ: if proc2Icache_addr line changes before acceptance, abandon and relatch new line address the same cycle (request with new address next cycle); if new address hits, return to IDLE.
REQ-019 WAIT: drive BUS_NONE; when mem2proc_tag == pending tag and nonzero, write mem2proc_data into latched index, set valid, store latched tag, clear pending tag, go IDLE.
REQ-020 WAIT: fetch-address change (branch redirect) does not cancel the fill; fill completes into its own latched index; new miss serviced after return to IDLE.
REQ-021 Fill write is registered; a lookup of the filled line is a hit from the cycle after the fill, no same-cycle bypass.
REQ-022 mem2proc_tag values not equal to pending tag are ignored.
REQ-023 Icache2proc_data_valid is low in REQ and WAIT unless current address hits an existing valid line.

Reset
REQ-024 Asserting reset clears all valid bits, FSM to IDLE, pending tag and latched address to 0, proc2mem_command to BUS_NONE, Icache2proc_data_valid to 0, immediately and independently of clock.
REQ-025 Reset mid-miss abandons the transaction; late returning data is ignored since pending tag is 0.
REQ-026 Data array contents need not reset.

Structure
REQ-027 BUS_NONE/BUS_LOAD encoding, XLEN and the FSM state enum live in the shared sys_defs package/header.
REQ-028 Tag/valid/data storage SHALL be one sub-module, icache_mem (single write port, one asynchronous read port, valid bits async-reset).

Verification
REQ-029 Reset, addr=0x0 -> valid=0, next cycle BUS_LOAD addr 0x0; response=3, tag=3 with data 0xDEADBEEF_00000013 two cycles later -> valid=1, data matches cycle after fill.
REQ-030 Rejection: response=0 for 3 cycles then 5 -> BUS_LOAD held 4 cycles with constant address, then BUS_NONE.
REQ-031 Redirect in REQ: addr 0x100 then 0x208 before acceptance -> proc2mem_addr switches to 0x208; no fill for 0x100.
REQ-032 Redirect in WAIT: miss 0x40 accepted tag 2, addr changes to 0x80 -> fill written at 0x40's index, then BUS_LOAD 0x80; later access 0x40 hits.
REQ-033 Conflict: fill 0x0, then fill 0x100 (same index, NUM_LINES=32) -> 0x0 misses, 0x100 hits; stray mem2proc_tag=7 during WAIT for tag 2 ignored.
REQ-034 Reset asserted in WAIT with tag 4 pending, deasserted, tag 4 data arrives -> no write, valid stays 0.
